cmsdk_mcu_mtxp_default_slave: RTL and testbench



---
 rtl/cmsdk_mcu_mtxp_default_slave.sv | 143 ++++++++++++++
 tb/tb_cmsdk_mcu_mtxp_default_slave.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/cmsdk_mcu_mtxp_default_slave.sv
// AHB matrix default slave: programmable wait states, two-cycle ERROR response,
// plus last-error capture registers and a saturating error counter with interrupt.
module cmsdk_mcu_mtxp_default_slave #(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned MASTER_WIDTH = 4,
    parameter int unsigned WAIT_STATES  = 0,
    parameter int unsigned CNT_WIDTH    = 8,
    parameter bit          IRQ_EN       = 1'b1
) (
    input  logic                    HCLK,
    input  logic                    HRESET,
    input  logic                    HSEL,
    input  logic [1:0]              HTRANS,
    input  logic                    HREADY,
    input  logic [ADDR_WIDTH-1:0]   HADDR,
    input  logic                    HWRITE,
    input  logic [MASTER_WIDTH-1:0] HMASTER,
    input  logic                    ERRCLR,
    output logic                    HREADYOUT,
    output logic [1:0]              HRESP,
    output logic [ADDR_WIDTH-1:0]   ERRADDR,
    output logic                    ERRWRITE,
    output logic [MASTER_WIDTH-1:0] ERRMASTER,
    output logic [CNT_WIDTH-1:0]    ERRCNT,
    output logic                    ERRIRQ
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ERR1 = 2'd2;
    localparam logic [1:0] ST_ERR2 = 2'd3;

    localparam logic [3:0] WAIT_LOAD = 4'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [1:0]              state_q, state_d;
    logic [3:0]              wait_cnt_q, wait_cnt_d;
    logic                    hreadyout_q, hreadyout_d;
    logic [1:0]              hresp_q, hresp_d;
    logic [ADDR_WIDTH-1:0]   erraddr_q, erraddr_d;
    logic                    errwrite_q, errwrite_d;
    logic [MASTER_WIDTH-1:0] errmaster_q, errmaster_d;
    logic [CNT_WIDTH-1:0]    errcnt_q, errcnt_d;
    logic                    errirq_q, errirq_d;

    logic trans_active;
    logic acc;
    logic take;

    // NONSEQ and SEQ request a transfer; IDLE and BUSY do not.
    assign trans_active = (HTRANS == 2'b10) || (HTRANS == 2'b11);
    assign acc          = HSEL & HREADY & trans_active;
    assign take         = acc & ((state_q == ST_IDLE) | (state_q == ST_ERR2));

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            ST_IDLE, ST_ERR2: begin
                if (take) begin
                    if (WAIT_STATES > 0) begin
                        state_d    = ST_WAIT;
                        wait_cnt_d = WAIT_LOAD;
                    end else begin
                        state_d = ST_ERR1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_q == 4'd0) begin
                    state_d = ST_ERR1;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered, so decode them from the next state.
        hreadyout_d = (state_d == ST_IDLE) || (state_d == ST_ERR2);
        hresp_d     = ((state_d == ST_ERR1) || (state_d == ST_ERR2)) ? 2'b01 : 2'b00;
    end

    always_comb begin
        erraddr_d   = erraddr_q;
        errwrite_d  = errwrite_q;
        errmaster_d = errmaster_q;
        errcnt_d    = errcnt_q;
        // A new error in the same cycle as ERRCLR wins and restarts the count at 1.
        if (take) begin
            erraddr_d   = HADDR;
            errwrite_d  = HWRITE;
            errmaster_d = HMASTER;
            if (ERRCLR) begin
                errcnt_d = CNT_ONE;
            end else if (errcnt_q != '1) begin
                errcnt_d = errcnt_q + CNT_ONE;
            end
        end else if (ERRCLR) begin
            erraddr_d   = '0;
            errwrite_d  = 1'b0;
            errmaster_d = '0;
            errcnt_d    = '0;
        end
        errirq_d = IRQ_EN && (errcnt_d != '0);
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q     <= ST_IDLE;
            wait_cnt_q  <= 4'd0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 2'b00;
            erraddr_q   <= '0;
            errwrite_q  <= 1'b0;
            errmaster_q <= '0;
            errcnt_q    <= '0;
            errirq_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
            erraddr_q   <= erraddr_d;
            errwrite_q  <= errwrite_d;
            errmaster_q <= errmaster_d;
            errcnt_q    <= errcnt_d;
            errirq_q    <= errirq_d;
        end
    end

    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;
    assign ERRADDR   = erraddr_q;
    assign ERRWRITE  = errwrite_q;
    assign ERRMASTER = errmaster_q;
    assign ERRCNT    = errcnt_q;
    assign ERRIRQ    = errirq_q;

endmodule

// File: tb/tb_cmsdk_mcu_mtxp_default_slave.sv
// Directed bench for the matrix default slave: three instances (0 waits, 3 waits,
// 2-bit counter) share one stimulus stream; each test checks the instance it targets.
module tb_cmsdk_mcu_mtxp_default_slave;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        HSEL;
    logic [1:0]  HTRANS;
    logic        HREADY;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [3:0]  HMASTER;
    logic        ERRCLR;

    logic        a_rdy, b_rdy, c_rdy;
    logic [1:0]  a_resp, b_resp, c_resp;
    logic [31:0] a_addr, b_addr, c_addr;
    logic        a_wr, b_wr, c_wr;
    logic [3:0]  a_mst, b_mst, c_mst;
    logic [7:0]  a_cnt, b_cnt;
    logic [1:0]  c_cnt;
    logic        a_irq, b_irq, c_irq;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 HCLK = ~HCLK;

    cmsdk_mcu_mtxp_default_slave #(.WAIT_STATES(0)) u_a (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HTRANS(HTRANS), .HREADY(HREADY),
        .HADDR(HADDR), .HWRITE(HWRITE), .HMASTER(HMASTER), .ERRCLR(ERRCLR),
        .HREADYOUT(a_rdy), .HRESP(a_resp), .ERRADDR(a_addr), .ERRWRITE(a_wr),
        .ERRMASTER(a_mst), .ERRCNT(a_cnt), .ERRIRQ(a_irq)
    );

    cmsdk_mcu_mtxp_default_slave #(.WAIT_STATES(3)) u_b (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HTRANS(HTRANS), .HREADY(HREADY),
        .HADDR(HADDR), .HWRITE(HWRITE), .HMASTER(HMASTER), .ERRCLR(ERRCLR),
        .HREADYOUT(b_rdy), .HRESP(b_resp), .ERRADDR(b_addr), .ERRWRITE(b_wr),
        .ERRMASTER(b_mst), .ERRCNT(b_cnt), .ERRIRQ(b_irq)
    );

    cmsdk_mcu_mtxp_default_slave #(.WAIT_STATES(0), .CNT_WIDTH(2)) u_c (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HTRANS(HTRANS), .HREADY(HREADY),
        .HADDR(HADDR), .HWRITE(HWRITE), .HMASTER(HMASTER), .ERRCLR(ERRCLR),
        .HREADYOUT(c_rdy), .HRESP(c_resp), .ERRADDR(c_addr), .ERRWRITE(c_wr),
        .ERRMASTER(c_mst), .ERRCNT(c_cnt), .ERRIRQ(c_irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Step one clock edge and settle just after it.
    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic bus_idle();
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        ERRCLR = 1'b0;
    endtask

    task automatic nonseq(input logic [31:0] addr, input logic wr, input logic [3:0] mst);
        HSEL    = 1'b1;
        HTRANS  = 2'b10;
        HADDR   = addr;
        HWRITE  = wr;
        HMASTER = mst;
    endtask

    task automatic do_reset();
        bus_idle();
        HRESET = 1'b1;
        tick();
        tick();
        HRESET = 1'b0;
    endtask

    task automatic check_a(input string tag, input logic rdy, input logic [1:0] resp);
        check({tag, "_rdy"}, {31'd0, a_rdy}, {31'd0, rdy});
        check({tag, "_resp"}, {30'd0, a_resp}, {30'd0, resp});
    endtask

    task automatic check_b(input string tag, input logic rdy, input logic [1:0] resp);
        check({tag, "_rdy"}, {31'd0, b_rdy}, {31'd0, rdy});
        check({tag, "_resp"}, {30'd0, b_resp}, {30'd0, resp});
    endtask

    initial begin
        HREADY  = 1'b1;
        HADDR   = 32'd0;
        HWRITE  = 1'b0;
        HMASTER = 4'd0;
        do_reset();

        // Reset state
        check_a("rst", 1'b1, 2'b00);
        check("rst_cnt", {24'd0, a_cnt}, 32'd0);
        check("rst_irq", {31'd0, a_irq}, 32'd0);
        check("rst_addr", a_addr, 32'd0);

        // 1: zero-wait read error and capture
        nonseq(32'h4000_0010, 1'b0, 4'd2);
        tick();
        bus_idle();
        check_a("t1_err1", 1'b0, 2'b01);
        check("t1_addr", a_addr, 32'h4000_0010);
        check("t1_mst", {28'd0, a_mst}, 32'd2);
        check("t1_wr", {31'd0, a_wr}, 32'd0);
        check("t1_cnt", {24'd0, a_cnt}, 32'd1);
        check("t1_irq", {31'd0, a_irq}, 32'd1);
        tick();
        check_a("t1_err2", 1'b1, 2'b01);
        tick();
        check_a("t1_idle", 1'b1, 2'b00);

        // 2: three wait states on a write
        do_reset();
        nonseq(32'h0000_0020, 1'b1, 4'd5);
        tick();
        bus_idle();
        for (int i = 0; i < 3; i++) begin
            check_b("t2_wait", 1'b0, 2'b00);
            tick();
        end
        check_b("t2_err1", 1'b0, 2'b01);
        check("t2_wr", {31'd0, b_wr}, 32'd1);
        tick();
        check_b("t2_err2", 1'b1, 2'b01);
        tick();
        check_b("t2_idle", 1'b1, 2'b00);

        // 3: back-to-back error accepted in ERR2
        do_reset();
        nonseq(32'h0000_0010, 1'b0, 4'd1);
        tick();
        HADDR = 32'h0000_0014;
        check_a("t3_err1a", 1'b0, 2'b01);
        tick();
        check_a("t3_err2a", 1'b1, 2'b01);
        check("t3_addr_a", a_addr, 32'h0000_0010);
        tick();
        bus_idle();
        check_a("t3_err1b", 1'b0, 2'b01);
        check("t3_addr_b", a_addr, 32'h0000_0014);
        check("t3_cnt", {24'd0, a_cnt}, 32'd2);
        tick();
        check_a("t3_err2b", 1'b1, 2'b01);
        tick();
        check_a("t3_idle", 1'b1, 2'b00);

        // 4: 2-bit counter saturation and ERRCLR
        do_reset();
        for (int i = 0; i < 5; i++) begin
            nonseq(32'h100 + 32'(i), 1'b0, 4'd3);
            tick();
            bus_idle();
            check("t4_sat", {30'd0, c_cnt}, (i < 3) ? 32'(i + 1) : 32'd3);
            tick();
            tick();
        end
        nonseq(32'h0000_0200, 1'b1, 4'd7);
        ERRCLR = 1'b1;
        tick();
        bus_idle();
        check("t4_clr_new", {30'd0, c_cnt}, 32'd1);
        check("t4_clr_addr", c_addr, 32'h0000_0200);
        tick();
        tick();
        ERRCLR = 1'b1;
        tick();
        ERRCLR = 1'b0;
        check("t4_clr_cnt", {30'd0, c_cnt}, 32'd0);
        check("t4_clr_irq", {31'd0, c_irq}, 32'd0);
        check("t4_clr_cap", c_addr, 32'd0);

        // 5: non-accepted cycles give zero-wait OKAY and change nothing
        do_reset();
        nonseq(32'h0000_0300, 1'b0, 4'd4);
        tick();
        bus_idle();
        tick();
        tick();
        HSEL = 1'b1;
        HTRANS = 2'b00;
        HADDR = 32'h0000_0400;
        tick();
        check_a("t5_idle", 1'b1, 2'b00);
        HTRANS = 2'b01;
        tick();
        check_a("t5_busy", 1'b1, 2'b00);
        HSEL = 1'b0;
        HTRANS = 2'b10;
        tick();
        check_a("t5_nosel", 1'b1, 2'b00);
        HSEL = 1'b1;
        HREADY = 1'b0;
        tick();
        check_a("t5_nordy", 1'b1, 2'b00);
        HREADY = 1'b1;
        bus_idle();
        check("t5_cnt", {24'd0, a_cnt}, 32'd1);
        check("t5_addr", a_addr, 32'h0000_0300);

        // 6: reset during ERR1 abandons the response
        do_reset();
        nonseq(32'h0000_0500, 1'b0, 4'd6);
        tick();
        bus_idle();
        check_a("t6_err1", 1'b0, 2'b01);
        HRESET = 1'b1;
        tick();
        HRESET = 1'b0;
        check_a("t6_rst", 1'b1, 2'b00);
        check("t6_cnt", {24'd0, a_cnt}, 32'd0);
        nonseq(32'h0000_0600, 1'b0, 4'd6);
        tick();
        bus_idle();
        check_a("t6_err1b", 1'b0, 2'b01);
        check("t6_cnt_b", {24'd0, a_cnt}, 32'd1);
        tick();
        check_a("t6_err2b", 1'b1, 2'b01);
        tick();
        check_a("t6_idleb", 1'b1, 2'b00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
